// File: rtl/bios_load_ctrl_if.sv
// Signal bundle between the hps_io download port, the system CPU and the shared
// BIOS/program RAM. The controller takes the slave view; the surrounding system takes the master view.
interface bios_load_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  // ioctl download side
  logic              dn_download;
  logic [7:0]        dn_index;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;

  // CPU side
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_dout_valid;
  logic              cpu_reset;

  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  logic              busy;

  modport slave (
    input  dn_download, dn_index, dn_wr, dn_addr, dn_data,
    input  cpu_addr, cpu_din, cpu_rd, cpu_wr, ram_dout,
    output cpu_dout, cpu_dout_valid, cpu_reset,
    output ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output dn_download, dn_index, dn_wr, dn_addr, dn_data,
    output cpu_addr, cpu_din, cpu_rd, cpu_wr, ram_dout,
    input  cpu_dout, cpu_dout_valid, cpu_reset,
    input  ram_addr, ram_din, ram_we, busy
  );
endinterface

// File: rtl/bios_load_ctrl.sv
// Arbitrates the shared BIOS/program RAM: ioctl download, zero-fill of the unused
// tail, a reset-hold settle period, then pass-through of CPU read/write cycles.
module bios_load_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int MAX_INDEX   = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk_sys_i,
  input  logic             reset_i,
  bios_load_ctrl_if.slave  ctrl_if
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) + 1 : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_FILL,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] hwm_q, hwm_d;
  logic              written_q, written_d;
  logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic              dl_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              rd_pend_q, rd_pend_d;
  logic              dout_valid_q;

  logic dl;
  logic dl_rise;

  assign dl      = ctrl_if.dn_download && (ctrl_if.dn_index < 8'(MAX_INDEX));
  assign dl_rise = dl && !dl_q;

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      hwm_q        <= '0;
      written_q    <= 1'b0;
      fill_ptr_q   <= '0;
      dl_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      rd_pend_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hwm_q        <= hwm_d;
      written_q    <= written_d;
      fill_ptr_q   <= fill_ptr_d;
      dl_q         <= dl;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      cpu_reset_q  <= cpu_reset_d;
      rd_pend_q    <= rd_pend_d;
      dout_valid_q <= rd_pend_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hwm_d       = hwm_q;
    written_d   = written_q;
    fill_ptr_d  = fill_ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    rd_pend_d   = 1'b0;
    cpu_reset_d = 1'b1;

    case (state_q)
      S_LOAD: begin
        if (dl && ctrl_if.dn_wr) begin
          ram_we_d   = 1'b1;
          ram_addr_d = ctrl_if.dn_addr;
          ram_din_d  = ctrl_if.dn_data;
          hwm_d      = (!written_q || (ctrl_if.dn_addr > hwm_q)) ? ctrl_if.dn_addr : hwm_q;
          written_d  = 1'b1;
        end
        if (!dl) begin
          // A download that already reached the top address leaves nothing to fill.
          if (written_q && (&hwm_q)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else begin
            state_d    = S_FILL;
            fill_ptr_d = written_q ? (hwm_q + 1'b1) : '0;
          end
        end
      end

      S_FILL: begin
        ram_we_d   = 1'b1;
        ram_addr_d = fill_ptr_q;
        ram_din_d  = '0;
        if (&fill_ptr_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          fill_ptr_d = fill_ptr_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // A simultaneous read and write performs the write only.
        if (ctrl_if.cpu_wr) begin
          ram_we_d   = 1'b1;
          ram_addr_d = ctrl_if.cpu_addr;
          ram_din_d  = ctrl_if.cpu_din;
        end else if (ctrl_if.cpu_rd) begin
          ram_addr_d = ctrl_if.cpu_addr;
          rd_pend_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    // A new download pre-empts everything; a fill in progress is abandoned, but a
    // CPU access issued in this last RUN cycle still completes.
    if (dl_rise) begin
      state_d   = S_LOAD;
      hwm_d     = '0;
      written_d = 1'b0;
      cnt_d     = '0;
      if (state_q == S_FILL) begin
        ram_we_d = 1'b0;
      end
    end

    cpu_reset_d = (state_d != S_RUN);
  end

  assign ctrl_if.ram_addr       = ram_addr_q;
  assign ctrl_if.ram_din        = ram_din_q;
  assign ctrl_if.ram_we         = ram_we_q;
  assign ctrl_if.cpu_reset      = cpu_reset_q;
  assign ctrl_if.cpu_dout       = ctrl_if.ram_dout;
  assign ctrl_if.cpu_dout_valid = dout_valid_q;
  assign ctrl_if.busy           = (state_q != S_RUN);

endmodule

// File: tb/tb_bios_load_ctrl.sv
// Scoreboard bench for bios_load_ctrl: stimulus queues expected RAM writes and
// read data; a negedge monitor pops and compares whenever the DUT emits one.
module tb_bios_load_ctrl;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bios_load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bios_load_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_INDEX(2), .HOLD_CYCLES(16)
  ) dut (
    .clk_sys_i (clk),
    .reset_i   (rst),
    .ctrl_if   (bus.slave)
  );

  // Behavioural RAM with synchronous read, one-cycle latency.
  logic [DW-1:0] mem [0:(2**AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;
  int n;
  logic [AW+DW-1:0] exp_wr_q [$];
  logic [DW-1:0]    exp_rd_q [$];
  logic [AW+DW-1:0] exp_wr;
  logic [DW-1:0]    exp_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        total++;
        if (exp_wr_q.size() == 0) begin
          bad++;
          $display("FAIL ram_write: got addr=%0h data=%0h want no write", bus.ram_addr, bus.ram_din);
        end else begin
          exp_wr = exp_wr_q.pop_front();
          if ({bus.ram_addr, bus.ram_din} !== exp_wr) begin
            bad++;
            $display("FAIL ram_write: got addr=%0h data=%0h want addr=%0h data=%0h",
                     bus.ram_addr, bus.ram_din, exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]);
          end
        end
      end
      if (bus.cpu_dout_valid) begin
        total++;
        if (exp_rd_q.size() == 0) begin
          bad++;
          $display("FAIL cpu_read: got data=%0h want no valid pulse", bus.cpu_dout);
        end else begin
          exp_rd = exp_rd_q.pop_front();
          if (bus.cpu_dout !== exp_rd) begin
            bad++;
            $display("FAIL cpu_read: got data=%0h want %0h", bus.cpu_dout, exp_rd);
          end else begin
            $display("ok   cpu_read: %0h", bus.cpu_dout);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dn_download = 1'b0; bus.dn_index = 8'd0; bus.dn_wr = 1'b0;
    bus.dn_addr = '0; bus.dn_data = '0;
    bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;

    // Reset state
    #12;
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_din", 32'(bus.ram_din), 32'd0);
    check("rst_valid", 32'(bus.cpu_dout_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Power-on: 16 cycles of hold, then RUN
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("por_hold", 32'(bus.cpu_reset), 32'd1);
    end
    tick();
    check("por_run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("por_run_busy", 32'(bus.busy), 32'd0);

    // Download of two bytes, then zero-fill of 2..16383
    bus.dn_index = 8'd0; bus.dn_download = 1'b1;
    tick();
    check("dl_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("dl_busy", 32'(bus.busy), 32'd1);
    bus.dn_wr = 1'b1; bus.dn_addr = 14'd0; bus.dn_data = 8'hA5;
    exp_wr_q.push_back({14'd0, 8'hA5});
    tick();
    bus.dn_addr = 14'd1; bus.dn_data = 8'h5A;
    exp_wr_q.push_back({14'd1, 8'h5A});
    tick();
    bus.dn_wr = 1'b0; bus.dn_download = 1'b0;
    for (int a = 2; a < 2**AW; a++) exp_wr_q.push_back({AW'(a), 8'h00});
    tick();
    n = 0;
    while (bus.cpu_reset && n < 20000) begin tick(); n++; end
    check("fill_hold_len", 32'(n), 32'd16398);
    check("fill_queue_drained", 32'(exp_wr_q.size()), 32'd0);

    // Non-BIOS index: strobes ignored
    bus.dn_index = 8'd2; bus.dn_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dn_wr = 1'b1; bus.dn_addr = 14'd5; bus.dn_data = 8'h77;
      tick();
      check("idx2_ram_we", 32'(bus.ram_we), 32'd0);
      check("idx2_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    end
    bus.dn_wr = 1'b0; bus.dn_download = 1'b0; bus.dn_index = 8'd0;
    tick();

    // CPU write then read back
    bus.cpu_wr = 1'b1; bus.cpu_addr = 14'h0100; bus.cpu_din = 8'h3C;
    exp_wr_q.push_back({14'h0100, 8'h3C});
    tick();
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1;
    exp_rd_q.push_back(8'h3C);
    tick();
    bus.cpu_rd = 1'b0;
    check("rd_addr_t1", 32'(bus.ram_addr), 32'h0100);
    check("rd_valid_t1", 32'(bus.cpu_dout_valid), 32'd0);
    tick();
    check("rd_valid_t2", 32'(bus.cpu_dout_valid), 32'd1);
    check("rd_data_t2", 32'(bus.cpu_dout), 32'h3C);
    tick();
    check("rd_valid_t3", 32'(bus.cpu_dout_valid), 32'd0);

    // Read and write together: write only
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 14'h0200; bus.cpu_din = 8'h11;
    exp_wr_q.push_back({14'h0200, 8'h11});
    tick();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    check("rw_ram_we", 32'(bus.ram_we), 32'd1);
    tick();
    tick();
    check("rw_no_valid", 32'(bus.cpu_dout_valid), 32'd0);

    // Download interrupted mid-fill, then top-address-only download
    bus.dn_index = 8'd1; bus.dn_download = 1'b1;
    tick();
    bus.dn_wr = 1'b1; bus.dn_addr = 14'd0; bus.dn_data = 8'h42;
    exp_wr_q.push_back({14'd0, 8'h42});
    tick();
    bus.dn_wr = 1'b0; bus.dn_download = 1'b0;
    for (int a = 1; a < 14'h0800; a++) exp_wr_q.push_back({AW'(a), 8'h00});
    tick();
    n = 0;
    while (!(bus.ram_we && bus.ram_addr == 14'h07FF) && n < 5000) begin tick(); n++; end
    check("fill_reach_7ff", 32'(n), 32'd2047);
    bus.dn_index = 8'd0; bus.dn_download = 1'b1;
    tick();
    check("abort_ram_we", 32'(bus.ram_we), 32'd0);
    check("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("abort_queue", 32'(exp_wr_q.size()), 32'd0);
    tick();
    check("abort_no_resume", 32'(bus.ram_we), 32'd0);
    bus.dn_wr = 1'b1; bus.dn_addr = 14'h3FFF; bus.dn_data = 8'hEE;
    exp_wr_q.push_back({14'h3FFF, 8'hEE});
    tick();
    bus.dn_wr = 1'b0; bus.dn_download = 1'b0;
    tick();
    n = 0;
    while (bus.cpu_reset && n < 1000) begin tick(); n++; end
    check("top_skip_fill_hold", 32'(n), 32'd16);

    // Asynchronous reset in the middle of a load
    bus.dn_download = 1'b1;
    tick();
    bus.dn_wr = 1'b1; bus.dn_addr = 14'd3; bus.dn_data = 8'h09;
    exp_wr_q.push_back({14'd3, 8'h09});
    tick();
    bus.dn_wr = 1'b0;
    check("load_ram_we", 32'(bus.ram_we), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; bus.dn_download = 1'b0;
    #1;
    check("arst_ram_we", 32'(bus.ram_we), 32'd0);
    check("arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (bus.cpu_reset && n < 1000) begin tick(); n++; end
    check("arst_hold_len", 32'(n), 32'd16);

    tick();
    check("end_wr_queue", 32'(exp_wr_q.size()), 32'd0);
    check("end_rd_queue", 32'(exp_rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
